fir_sample_capture: RTL and testbench
=====================================

// Module: fir_sample_capture
// PURPOSE
//   Sink end of the FIR sample stream: captures FIR_Filters data_out samples
//   into an on-chip buffer after a programmable settling skip, with running
//   min/max/sum statistics. Read port gives random-access readback for the
//   bench or a host. Mirror of the stimulus RAM that feeds data_in.
// PARAMETERS
//   N      16   sample width, two's complement
//   DEPTH  100  capture buffer depth, in samples
//   AW     7    address width; 2**AW >= DEPTH
//   SKIP   8    valid samples discarded after start, for filter settling; 0 = none
// PORTS
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous, active-low reset
//   start      in   1       1-cycle pulse: begin a capture run
//   abort      in   1       abandon the run, return to IDLE
//   in_valid   in   1       in_data holds a sample this cycle
//   in_data    in   N       FIR output sample, signed
//   busy       out  1       high in SKIP or CAPTURE
//   done       out  1       high in DONE, buffer full
//   count      out  AW+1    samples captured in the current run
//   max_val    out  N       signed maximum of the captured samples
//   min_val    out  N       signed minimum of the captured samples
//   sum        out  N+AW+1  signed sum of the captured samples
//   rd_en      in   1       read request
//   rd_addr    in   AW      read address
//   rd_data    out  N       read data, 1-cycle latency
// BEHAVIOUR
//   - Reset (reset=0, async) forces:
//     - state IDLE; busy, done, count, max_val, min_val, sum, rd_data = 0.
//     - Buffer contents are not cleared; they are undefined after reset.
//   - FSM states: IDLE, SKIP, CAPTURE, DONE.
//     - IDLE/DONE + start: clear count and sum; max_val=-2**(N-1);
//       min_val=2**(N-1)-1; skip counter=0. Go to SKIP, or to CAPTURE if SKIP==0.
//     - SKIP: each in_valid increments the skip counter. The cycle the
//       SKIP-th valid sample arrives, go to CAPTURE; that sample is not stored.
//     - CAPTURE: in_valid writes buf[count]=in_data, count+1, updates
//       max/min/sum; no write without in_valid. The sample that makes
//       count==DEPTH moves the FSM to DONE in the same edge.
//     - DONE: hold statistics and count; ignore further in_valid.
//     - start while in SKIP/CAPTURE: ignored.
//     - abort in any state: go to IDLE next edge, keep count and statistics;
//       abort wins over a simultaneous start.
//   - busy and done are registered decodes of the state, valid the cycle
//     after the transition edge.
//   - Statistics: signed compares; sum sign-extends in_data to N+AW+1 bits and
//     cannot overflow for DEPTH <= 2**AW.
//   - Readback: works in every state. rd_en at edge k puts buf[rd_addr] on
//     rd_data after edge k (1-cycle latency); rd_data holds when rd_en=0.
//     rd_addr >= DEPTH returns 0.
//   - Same-cycle read and write of one address: rd_data returns the old word
//     (read-before-write).
// TESTING
//   - Reset mid-CAPTURE at count=37 -> all outputs 0, state IDLE, in_valid
//     then ignored until start.
//   - SKIP=8, ramp in_data=0,1,2,... valid every cycle, start ->
//     buf[0]=8, buf[99]=107, done at 108th valid, sum=5750, min=8, max=107.
//   - in_valid toggling 1,0,1,0 -> count advances only on valid; DEPTH
//     samples take 2*DEPTH cycles; nothing stored on invalid cycles.
//   - Signed data 16'h8000, 16'h7FFF, 16'hFFFF repeated ->
//     min_val=16'h8000, max_val=16'h7FFF, sum sign-correct.
//   - abort at count=50 then start -> count=0, stats re-initialised;
//     start during CAPTURE -> no effect.
//   - Read buf[5] in the cycle it is written -> old value;
//     rd_addr=100 -> rd_data=0; read in DONE -> captured value after 1 cycle.

Source files
------------

// File: rtl/fir_sample_capture.sv
// ---------------------------------------------------------------------------
// fir_sample_capture
//
// Sink end of the FIR sample stream. After a start pulse, the block first
// throws away SKIP valid samples so that the filter can settle. It then
// stores the next DEPTH valid samples in an on-chip buffer. While capturing,
// it keeps a running signed minimum, maximum and sum of the stored samples.
// A read port gives random-access readback of the buffer in every state.
//
// Parameters
//   N      sample width, two's complement
//   DEPTH  capture buffer depth in samples
//   AW     read address width, 2**AW >= DEPTH
//   SKIP   number of valid samples discarded after start (0 = none)
//
// Ports
//   clk       in   1        rising-edge clock
//   reset     in   1        asynchronous active-low reset
//   start     in   1        one-cycle pulse that begins a capture run
//   abort     in   1        abandons the run; wins over start
//   in_valid  in   1        in_data holds a sample this cycle
//   in_data   in   N        FIR output sample, signed
//   busy      out  1        registered: state is SKIP or CAPTURE
//   done      out  1        registered: state is DONE (buffer full)
//   count     out  AW+1     samples captured in the current run
//   max_val   out  N        signed maximum of the captured samples
//   min_val   out  N        signed minimum of the captured samples
//   sum       out  N+AW+1   signed sum of the captured samples
//   rd_en     in   1        read request
//   rd_addr   in   AW       read address
//   rd_data   out  N        read data, 1-cycle latency, holds when idle
// ---------------------------------------------------------------------------
module fir_sample_capture #(
    parameter int N     = 16,
    parameter int DEPTH = 100,
    parameter int AW    = 7,
    parameter int SKIP  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [N-1:0]      in_data,
    output logic              busy,
    output logic              done,
    output logic [AW:0]       count,
    output logic [N-1:0]      max_val,
    output logic [N-1:0]      min_val,
    output logic [N+AW:0]     sum,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [N-1:0]      rd_data
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam int SW   = (SKIP < 2) ? 1 : $clog2(SKIP + 1);
    localparam int SUMW = N + AW + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SKIP    = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    // With no settling skip the run goes straight to CAPTURE.
    localparam logic [1:0] S_FIRST = (SKIP == 0) ? S_CAPTURE : S_SKIP;

    // Skip-counter value held while the SKIP-th valid sample arrives.
    localparam logic [SW-1:0] SKIP_LAST = SW'((SKIP > 0) ? (SKIP - 1) : 0);

    // Count value held while the DEPTH-th sample is being written.
    localparam logic [AW:0] CNT_LAST = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0] DEPTH_W  = (AW + 1)'(DEPTH);

    // Statistic seeds: the first captured sample always replaces both.
    localparam logic [N-1:0] MAX_SEED = {1'b1, {(N - 1){1'b0}}};
    localparam logic [N-1:0] MIN_SEED = {1'b0, {(N - 1){1'b1}}};

    // -----------------------------------------------------------------------
    // Storage and state
    // -----------------------------------------------------------------------
    logic [N-1:0]    r_buf [0:DEPTH-1];
    logic [1:0]      r_state;
    logic [SW-1:0]   r_skip_cnt;
    logic [AW:0]     r_count;
    logic [N-1:0]    r_max;
    logic [N-1:0]    r_min;
    logic [SUMW-1:0] r_sum;
    logic            r_busy;
    logic            r_done;
    logic [N-1:0]    r_rd_data;

    logic [1:0]      w_state_nx;
    logic            w_init;
    logic            w_skip_adv;
    logic            w_wr;
    logic            w_rd_in_range;
    logic [SUMW-1:0] w_data_ext;
    logic            w_new_max;
    logic            w_new_min;

    assign w_data_ext    = {{(AW + 1){in_data[N-1]}}, in_data};
    assign w_rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
    assign w_new_max     = ($signed(in_data) > $signed(r_max));
    assign w_new_min     = ($signed(in_data) < $signed(r_min));

    // Next-state logic and the one-cycle control strobes derived from it.
    always_comb begin
        w_state_nx = r_state;
        w_init     = 1'b0;
        w_skip_adv = 1'b0;
        w_wr       = 1'b0;
        if (abort) begin
            // Abort wins over everything, including a simultaneous start.
            w_state_nx = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_init     = 1'b1;
                        w_state_nx = S_FIRST;
                    end else begin
                        w_state_nx = r_state;
                    end
                end
                S_SKIP: begin
                    if (in_valid) begin
                        if (r_skip_cnt == SKIP_LAST) begin
                            // This sample finishes the skip and is not stored.
                            w_state_nx = S_CAPTURE;
                        end else begin
                            w_skip_adv = 1'b1;
                        end
                    end else begin
                        w_state_nx = S_SKIP;
                    end
                end
                S_CAPTURE: begin
                    if (in_valid) begin
                        w_wr = 1'b1;
                        if (r_count == CNT_LAST) begin
                            w_state_nx = S_DONE;
                        end else begin
                            w_state_nx = S_CAPTURE;
                        end
                    end else begin
                        w_state_nx = S_CAPTURE;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end
    end

    // State register plus busy/done decoded from the next state so that they
    // change right after the transition edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_busy  <= (w_state_nx == S_SKIP) || (w_state_nx == S_CAPTURE);
            r_done  <= (w_state_nx == S_DONE);
        end
    end

    // Settling-skip counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_skip_cnt <= {SW{1'b0}};
        end else if (w_init) begin
            r_skip_cnt <= {SW{1'b0}};
        end else if (w_skip_adv) begin
            r_skip_cnt <= r_skip_cnt + {{(SW - 1){1'b0}}, 1'b1};
        end else begin
            r_skip_cnt <= r_skip_cnt;
        end
    end

    // Capture count and running statistics; held outside CAPTURE writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= {(AW + 1){1'b0}};
            r_max   <= {N{1'b0}};
            r_min   <= {N{1'b0}};
            r_sum   <= {SUMW{1'b0}};
        end else if (w_init) begin
            r_count <= {(AW + 1){1'b0}};
            r_max   <= MAX_SEED;
            r_min   <= MIN_SEED;
            r_sum   <= {SUMW{1'b0}};
        end else if (w_wr) begin
            r_count <= r_count + {{AW{1'b0}}, 1'b1};
            r_max   <= w_new_max ? in_data : r_max;
            r_min   <= w_new_min ? in_data : r_min;
            r_sum   <= r_sum + w_data_ext;
        end else begin
            r_count <= r_count;
            r_max   <= r_max;
            r_min   <= r_min;
            r_sum   <= r_sum;
        end
    end

    // Capture buffer write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_buf[r_count[AW-1:0]] <= in_data;
        end
    end

    // Registered read port. Because the write above is non-blocking, a read
    // of the address being written returns the old word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data <= {N{1'b0}};
        end else if (rd_en) begin
            r_rd_data <= w_rd_in_range ? r_buf[rd_addr] : {N{1'b0}};
        end else begin
            r_rd_data <= r_rd_data;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign count   = r_count;
    assign max_val = r_max;
    assign min_val = r_min;
    assign sum     = r_sum;
    assign rd_data = r_rd_data;

endmodule

// File: tb/tb_fir_sample_capture.sv
// ---------------------------------------------------------------------------
// tb_fir_sample_capture
//
// Self-checking bench for fir_sample_capture. A behavioural model tracks
// state, count, statistics and buffer contents from the driven stimulus.
// Expected read data is queued when a read is issued and popped when the
// DUT presents it one cycle later.
// ---------------------------------------------------------------------------
module tb_fir_sample_capture;

    localparam int N     = 16;
    localparam int DEPTH = 100;
    localparam int AW    = 7;
    localparam int SKIP  = 8;

    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_SKIP = 2'd1;
    localparam logic [1:0] M_CAP  = 2'd2;
    localparam logic [1:0] M_DONE = 2'd3;

    logic              clk;
    logic              reset;
    logic              start;
    logic              abort;
    logic              in_valid;
    logic [N-1:0]      in_data;
    logic              busy;
    logic              done;
    logic [AW:0]       count;
    logic [N-1:0]      max_val;
    logic [N-1:0]      min_val;
    logic [N+AW:0]     sum;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [N-1:0]      rd_data;

    fir_sample_capture #(
        .N(N), .DEPTH(DEPTH), .AW(AW), .SKIP(SKIP)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .busy(busy), .done(done),
        .count(count), .max_val(max_val), .min_val(min_val), .sum(sum),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model
    logic [1:0]  m_state;
    int          m_skip;
    int          m_cnt;
    logic [15:0] m_max;
    logic [15:0] m_min;
    logic [23:0] m_sum;
    logic [15:0] m_rd;
    logic [15:0] m_mem [0:DEPTH-1];
    logic [15:0] rd_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_skip  = 0;
        m_cnt   = 0;
        m_max   = 16'h0000;
        m_min   = 16'h0000;
        m_sum   = 24'h000000;
        m_rd    = 16'h0000;
        rd_q.delete();
    endtask

    // Applies one clock edge of spec behaviour to the model.
    task automatic model_step(input logic st, input logic ab, input logic v, input logic [15:0] d);
        if (ab) begin
            m_state = M_IDLE;
        end else begin
            case (m_state)
                M_IDLE, M_DONE: begin
                    if (st) begin
                        m_cnt   = 0;
                        m_sum   = 24'h000000;
                        m_max   = 16'h8000;
                        m_min   = 16'h7FFF;
                        m_skip  = 0;
                        m_state = (SKIP == 0) ? M_CAP : M_SKIP;
                    end
                end
                M_SKIP: begin
                    if (v) begin
                        m_skip++;
                        if (m_skip == SKIP) m_state = M_CAP;
                    end
                end
                M_CAP: begin
                    if (v) begin
                        m_mem[m_cnt] = d;
                        m_cnt++;
                        if ($signed(d) > $signed(m_max)) m_max = d;
                        if ($signed(d) < $signed(m_min)) m_min = d;
                        m_sum = m_sum + {{8{d[15]}}, d};
                        if (m_cnt == DEPTH) m_state = M_DONE;
                    end
                end
                default: m_state = M_IDLE;
            endcase
        end
    endtask

    // Drives one cycle of stimulus, advances the model and checks all outputs.
    task automatic tick(input logic st, input logic ab, input logic v, input logic [15:0] d,
                        input logic re, input logic [6:0] ra);
        start    = st;
        abort    = ab;
        in_valid = v;
        in_data  = d;
        rd_en    = re;
        rd_addr  = ra;
        // Expected read data captured before this edge's write (old word).
        if (re) rd_q.push_back((ra < 7'd100) ? m_mem[ra] : 16'h0000);
        model_step(st, ab, v, d);
        @(posedge clk);
        @(negedge clk);
        if (re) m_rd = rd_q.pop_front();
        check("rd_data", 32'(rd_data), 32'(m_rd));
        check("busy",    32'(busy),    32'((m_state == M_SKIP) || (m_state == M_CAP)));
        check("done",    32'(done),    32'(m_state == M_DONE));
        check("count",   32'(count),   32'(m_cnt));
        check("max_val", 32'(max_val), 32'(m_max));
        check("min_val", 32'(min_val), 32'(m_min));
        check("sum",     32'(sum),     32'(m_sum));
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        rd_en    = 1'b0;
    endtask

    task automatic do_start();
        tick(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 7'd0);
    endtask

    task automatic do_skip();
        for (int i = 0; i < SKIP; i++) tick(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 7'd0);
    endtask

    task automatic rd(input logic [6:0] a);
        tick(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, a);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(busy),    32'd0);
        check({tag, "_done"},  32'(done),    32'd0);
        check({tag, "_count"}, 32'(count),   32'd0);
        check({tag, "_max"},   32'(max_val), 32'd0);
        check({tag, "_min"},   32'(min_val), 32'd0);
        check({tag, "_sum"},   32'(sum),     32'd0);
        check({tag, "_rd"},    32'(rd_data), 32'd0);
    endtask

    logic [15:0] pat [0:2];

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0000;
        pat[0] = 16'h8000;
        pat[1] = 16'h7FFF;
        pat[2] = 16'hFFFF;
        reset    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        rd_en    = 1'b0;
        rd_addr  = 7'd0;
        model_reset();
        #12;
        check_all_zero("por");
        @(negedge clk);
        reset = 1'b1;

        // Ramp with settling skip.
        do_start();
        check("ramp_busy_after_start", 32'(busy), 32'd1);
        for (int k = 0; k < 108; k++) begin
            tick(1'b0, 1'b0, 1'b1, 16'(k), 1'b0, 7'd0);
            if (k == 106) check("ramp_not_done_107", 32'(done), 32'd0);
        end
        check("ramp_done",  32'(done),    32'd1);
        check("ramp_count", 32'(count),   32'd100);
        check("ramp_min",   32'(min_val), 32'd8);
        check("ramp_max",   32'(max_val), 32'd107);
        check("ramp_sum",   32'(sum),     32'd5750);
        tick(1'b0, 1'b0, 1'b1, 16'h00C8, 1'b0, 7'd0);
        check("ramp_done_ignores", 32'(count), 32'd100);
        rd(7'd0);
        check("ramp_buf0", 32'(rd_data), 32'd8);
        rd(7'd99);
        check("ramp_buf99", 32'(rd_data), 32'd107);
        tick(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 7'd3);
        check("rd_hold", 32'(rd_data), 32'd107);
        rd(7'd100);
        check("rd_oob", 32'(rd_data), 32'd0);

        // Reset in the middle of CAPTURE.
        do_start();
        do_skip();
        for (int k = 0; k < 37; k++) tick(1'b0, 1'b0, 1'b1, 16'(500 + k), 1'b0, 7'd0);
        check("mid_count37", 32'(count), 32'd37);
        reset = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) tick(1'b0, 1'b0, 1'b1, 16'h0055, 1'b0, 7'd0);
        check("midrst_ignored", 32'(count), 32'd0);

        // Alternating in_valid.
        do_start();
        do_skip();
        for (int i = 0; i < 200; i++) begin
            tick(1'b0, 1'b0, (i % 2) == 0, 16'(i), 1'b0, 7'd0);
            if (i == 197) check("tog_not_done", 32'(done), 32'd0);
        end
        check("tog_done",  32'(done),  32'd1);
        check("tog_count", 32'(count), 32'd100);
        rd(7'd1);
        check("tog_buf1", 32'(rd_data), 32'd2);
        rd(7'd99);
        check("tog_buf99", 32'(rd_data), 32'd198);

        // Signed extremes.
        do_start();
        do_skip();
        for (int k = 0; k < DEPTH; k++) tick(1'b0, 1'b0, 1'b1, pat[k % 3], 1'b0, 7'd0);
        check("sgn_min", 32'(min_val), 32'h0000_8000);
        check("sgn_max", 32'(max_val), 32'h0000_7FFF);
        check("sgn_sum", 32'(sum),     32'h00FF_7FBE);

        // Abort at count 50, start ignored mid-run, restart.
        do_start();
        do_skip();
        for (int k = 0; k < 50; k++) tick(k == 20, 1'b0, 1'b1, 16'(1000 + k), 1'b0, 7'd0);
        check("abt_count50", 32'(count), 32'd50);
        tick(1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 7'd0);
        check("abt_idle",  32'(busy),  32'd0);
        check("abt_kept",  32'(count), 32'd50);
        tick(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 7'd0);
        check("abt_wins_start", 32'(busy), 32'd0);
        do_start();
        check("rst_count", 32'(count),   32'd0);
        check("rst_max",   32'(max_val), 32'h0000_8000);
        check("rst_min",   32'(min_val), 32'h0000_7FFF);
        check("rst_sum",   32'(sum),     32'd0);
        do_skip();
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 1'b0, 1'b1, 16'(2000 + k), k == 5, 7'd5);
            if (k == 5) check("rbw_old", 32'(rd_data), 32'd1005);
        end
        rd(7'd5);
        check("rbw_new", 32'(rd_data), 32'd2005);
        tick(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 7'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
